// File: rtl/bsg_manycore_reg_id_encode.sv
// bsg_manycore_reg_id_encode: embeds reg_id into unwritten byte lanes of store requests, buffers them in order and limits outstanding stores with credits.
// Optional BSG_MANYCORE_REG_ID_DROP_EMPTY_STORE_EN: accept mask_i==0 requests without enqueueing them or consuming a credit.
module bsg_manycore_reg_id_encode #(
  parameter int data_width_p = 32,
  parameter int reg_id_width_p = 5,
  parameter int els_p = 2,
  parameter int max_out_p = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               v_i,
  output logic                               ready_o,
  input  logic [data_width_p-1:0]            data_i,
  input  logic [data_width_p/8-1:0]          mask_i,
  input  logic [reg_id_width_p-1:0]          reg_id_i,
  output logic                               v_o,
  input  logic                               yumi_i,
  output logic [data_width_p-1:0]            data_o,
  output logic [data_width_p/8-1:0]          mask_o,
  output logic [reg_id_width_p-1:0]          reg_id_o,
  input  logic                               credit_return_i,
  output logic [$clog2(max_out_p+1)-1:0]     credits_o,
  output logic                               error_o
);
  localparam int lanes_lp = data_width_p/8;
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p+1);
  localparam int cred_w_lp = $clog2(max_out_p+1);
  typedef struct packed {
    logic [data_width_p-1:0]   data;
    logic [lanes_lp-1:0]       mask;
    logic [reg_id_width_p-1:0] reg_id;
  } entry_t;
  entry_t mem_q [els_p];
  entry_t entry_d;
  logic [ptr_w_lp-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic [cred_w_lp-1:0] credits_q, credits_d;
  logic error_q, error_d;
  logic accept, enq, deq, overflow;
  assign ready_o = reset_n_i & (count_q != cnt_w_lp'(els_p)) & (credits_q != '0);
  assign accept = v_i & ready_o;
`ifdef BSG_MANYCORE_REG_ID_DROP_EMPTY_STORE_EN
  assign enq = accept & (|mask_i);
`else
  assign enq = accept;
`endif
  assign deq = yumi_i & v_o;
  assign overflow = ~enq & credit_return_i & (credits_q == cred_w_lp'(max_out_p));
  // encode at accept time so the FIFO holds ready-to-send words
  always_comb begin
    entry_d.data = data_i;
    entry_d.mask = mask_i;
    entry_d.reg_id = (&mask_i) ? reg_id_i : '0;
    for (int b = 0; b < lanes_lp; b++)
      entry_d.data[8*b +: 8] = mask_i[b] ? data_i[8*b +: 8] : 8'(reg_id_i);
  end
  always_comb begin
    wr_d = enq ? ((wr_q == ptr_w_lp'(els_p-1)) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = deq ? ((rd_q == ptr_w_lp'(els_p-1)) ? '0 : rd_q + 1'b1) : rd_q;
    count_d = count_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    credits_d = (enq & ~credit_return_i) ? credits_q - 1'b1
              : (~enq & credit_return_i & ~overflow) ? credits_q + 1'b1
              : credits_q;
    error_d = error_q | overflow;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      credits_q <= cred_w_lp'(max_out_p);
      error_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      credits_q <= credits_d;
      error_q <= error_d;
    end
    if (enq) mem_q[wr_q] <= entry_d;
  end
  assign v_o = (count_q != '0);
  assign data_o = mem_q[rd_q].data;
  assign mask_o = mem_q[rd_q].mask;
  assign reg_id_o = mem_q[rd_q].reg_id;
  assign credits_o = credits_q;
  assign error_o = error_q;
  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
endmodule

// File: doc/bsg_manycore_reg_id_encode.md
Name: bsg_manycore_reg_id_encode

Overview:
- Store-request side of the non-blocking store reg_id scheme.
- Accepts store requests (data, byte mask, reg_id) and embeds the reg_id into every byte lane the mask leaves unwritten, so the response-side decoder can recover it by OR-ing unmasked lanes.
- Buffers requests in a small in-order FIFO.
- Limits outstanding stores with a credit counter that is replenished by store responses.

Parameters:
- data_width_p, 32, store data width; 4 byte lanes at the default.
- reg_id_width_p, bsg_manycore_reg_id_width_gp (5), reg_id width; must be ≤ 8.
- els_p, 2, FIFO depth; must be ≥ 2.
- max_out_p, 16, maximum outstanding stores (credits).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous active-low reset.
- v_i  in  1  input store valid.
- ready_o  out  1  input can be accepted.
- data_i  in  data_width_p  store data.
- mask_i  in  data_width_p/8  byte-write mask; 1 = lane written.
- reg_id_i  in  reg_id_width_p  destination reg_id.
- v_o  out  1  output valid.
- yumi_i  in  1  downstream consumes output; legal only when v_o=1.
- data_o  out  data_width_p  encoded data.
- mask_o  out  data_width_p/8  byte mask, passed through.
- reg_id_o  out  reg_id_width_p  reg_id for full-word stores; 0 otherwise.
- credit_return_i  in  1  one store response received.
- credits_o  out  clog2(max_out_p+1)  credits currently available.
- error_o  out  1  sticky credit-underflow error.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-low on reset_n_i, sampled at the rising edge of clk_i.
  - During and after reset: FIFO empty, v_o=0, credits_o=max_out_p, error_o=0.
  - ready_o is 0 while reset_n_i=0.
  - Reset mid-operation discards all FIFO contents and restores full credits.
- Acceptance: accept = v_i & ready_o.
  - ready_o = FIFO not full & credits_o≠0.
  - ready_o must not depend on v_i.
- Encoding, applied at accept and stored already encoded:
  - Each lane b with mask_i[b]=0: data lane b = reg_id_i zero-extended to 8 bits.
  - Each lane b with mask_i[b]=1: lane carries data_i unchanged.
  - mask_i all-ones: data unchanged; reg_id_o=reg_id_i.
  - Otherwise reg_id_o=0.
- Output:
  - FIFO is in-order, els_p entries, registered output.
  - Latency 1 cycle: an entry accepted at edge N presents v_o=1 from cycle N+1.
  - data_o, mask_o and reg_id_o hold stable while v_o=1 and yumi_i=0.
  - Dequeue on yumi_i.
- Full/empty:
  - Full FIFO: ready_o=0.
  - If full and yumi_i=1 in the same cycle, ready_o stays 0 that cycle. No combinational yumi→ready path.
  - Empty FIFO: v_o=0.
  - Simultaneous enqueue and dequeue at occupancy 1 keeps occupancy 1.
- Credits:
  - Accept decrements credits_o.
  - credit_return_i increments credits_o.
  - Accept and return in the same cycle: no change.
  - credit_return_i when credits_o=max_out_p and no simultaneous accept: credits_o holds at max_out_p and error_o sets. error_o is cleared only by reset.
  - credits_o=0: ready_o=0 until a return is registered, i.e. the cycle after credit_return_i.
- yumi_i with v_o=0 is illegal. Behaviour is unspecified; assertion in simulation.
- Pointer wrap-around at els_p must preserve order.

Optional Feature:
- Macro: BSG_MANYCORE_REG_ID_DROP_EMPTY_STORE_EN.
- Defined:
  - A request with mask_i=0 is accepted (ready_o as normal) but not enqueued and consumes no credit.
  - ready_o for such a request still requires credits_o≠0, to keep ready_o independent of data.
- Undefined:
  - mask_i=0 is treated as a normal partial store.
  - All lanes carry the reg_id, reg_id_o=0, and one credit is consumed.

Test Plan:
- Partial store: data_i=0xAABBCCDD, mask_i=4'b0011, reg_id_i=5'd9, yumi_i held 1 → next cycle v_o=1, data_o=0x0909CCDD, mask_o=4'b0011, reg_id_o=0, credits_o=15.
- Full-word store: data_i=0x12345678, mask_i=4'hF, reg_id_i=5'd31 → data_o=0x12345678, reg_id_o=31.
- Backpressure: yumi_i=0, two accepts (reg_id 1, 2) → ready_o=0 on the third request; outputs stable. Then yumi_i=1 for two cycles → order reg_id 1 then 2; ready_o reasserts the cycle after the first dequeue.
- Credit exhaustion, max_out_p=16: 16 accepts with continuous yumi_i and no returns → credits_o=0, ready_o=0. One credit_return_i → credits_o=1, ready_o=1 the next cycle. Simultaneous accept+return at credits_o=1 → credits_o stays 1.
- Underflow and reset: credit_return_i at credits_o=16 → credits_o=16, error_o=1 (sticky). reset_n_i=0 mid-traffic with 1 entry queued → next cycle v_o=0, credits_o=16, error_o=0.
- Empty-mask store, mask_i=0, reg_id_i=3, data_i=0: macro defined → no v_o, credits_o unchanged. Macro undefined → data_o=0x03030303, credits_o decremented.
